div: RTL and testbench
======================

Name: div

Overview:
- Iterative 32-bit divider for DIV/DIVU, run by the EX stage.
- EX stage sits directly downstream of instruction decode. It receives aluop and the forwarded rs/rt operands, drives start_i, and stalls the pipeline until ready_o rises.
- Restoring algorithm, one quotient bit per clock.
- Result is {remainder, quotient}, which is written to HI/LO.

Parameters:
- DATA_W, 32, operand width. Iteration count equals DATA_W; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset. rst=0 resets immediately. This block does not use `RstEnable.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  in  32  dividend (rs).
- opdata2_i  in  32  divisor (rt).
- start_i  in  1  request. Held high by EX until ready_o is seen, then dropped.
- annul_i  in  1  cancel current operation (branch-delay flush or exception).
- result_o  out  64  {remainder[31:0], quotient[31:0]}. Valid only while ready_o=1.
- ready_o  out  1  result valid.

Behaviour:
- Reset (rst=0, async): state=DivFree, cnt=0, result_o=0, ready_o=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: DivFree, DivByZero, DivOn, DivEnd. Transitions are evaluated at each rising edge:
  - DivFree, start_i=1 and annul_i=0: latch operands and sign flag.
    - Divisor==0 → DivByZero.
    - Otherwise → DivOn, cnt=0.
  - DivFree, any other inputs: stay; ready_o=0, result_o=0.
  - DivByZero: → DivEnd with quotient=0, remainder=0.
  - DivOn, annul_i=1: → DivFree, ready_o=0, result_o=0. Partial results are discarded.
  - DivOn, annul_i=0: perform one iteration, cnt++. After the iteration with cnt==31 → DivEnd.
  - DivEnd: ready_o=1 and result_o = sign-corrected value. Stay while start_i=1. When start_i=0 → DivFree, ready_o=0, result_o=0.
- Iteration:
  - Registers: 33-bit partial remainder R, 32-bit quotient Q, 32-bit divisor D.
  - Step: {R,Q} <<= 1.
  - Compute 33-bit trial T = R − {1'b0,D}.
  - If T[32]==0: R=T and Q[0]=1.
  - Otherwise R and Q are unchanged.
- Signed handling (signed_div_i=1):
  - Operands are replaced by their two's-complement magnitudes at latch time.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- Latency, counting the start-sampling edge as edge 1:
  - Normal divide: ready_o high after edge 34.
  - Divide-by-zero: ready_o high after edge 3.
- Operand inputs are ignored after latching. Changing them mid-operation has no effect.
- start_i is ignored outside DivFree. A dropped start_i in DivOn does not abort; only annul_i aborts.
- annul_i in DivByZero or DivEnd: no effect beyond the normal flow (EX drops start_i on flush).
- annul_i and start_i both high in DivFree: stay in DivFree.
- Back-to-back divides need at least one cycle with start_i=0, so that DivEnd → DivFree occurs.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in DivFree, if |dividend| < |divisor| (unsigned magnitudes, divisor≠0), skip DivOn and go DivByZero-like → DivEnd.
  - Result: quotient=0, remainder=original signed dividend.
  - Latency is the same as divide-by-zero (ready after edge 3).
- Undefined: all non-zero divisors take the full 32 iterations.
- Results are identical either way; only latency differs.

Decomposition:
- defines.v holds:
  - State codes: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady/DivResultNotReady, DivStart/DivStop.
  - `DoubleRegBus 63:0.
  - `EXE_DIV_OP/`EXE_DIVU_OP, plus the EXE_DIV/EXE_DIVU function codes consumed by decode.
- Single module. No sub-module is needed; the sign fix-up and step logic are inline.

Test Plan:
- DIVU 100/7, start held → result_o=64'h00000002_0000000E, ready_o rises after edge 34, falls one edge after start_i drops.
- DIV −7/2 (0xFFFFFFF9/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 5/0 → result_o=0, ready_o after edge 3. Then DIVU 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0 after full latency.
- annul_i pulsed at cnt=10 → ready_o never rises, state returns to DivFree. Next DIVU 9/3 → quotient 3, remainder 0.
- rst driven low asynchronously mid-DivOn (between edges) → ready_o=0 and result_o=0 immediately. After release, a new start works.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative divider and its users.
//   - div_state_e : divider FSM state codes
//   - DIV_RESULT_READY / DIV_RESULT_NOT_READY, DIV_START / DIV_STOP
//   - EXE_DIV_OP / EXE_DIVU_OP : ALU op codes steered to the divider
//   - EXE_DIV / EXE_DIVU       : SPECIAL function codes seen by decode
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam int   DOUBLE_REG_W = 64;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [5:0] EXE_DIV     = 6'b01_1010;
  localparam logic [5:0] EXE_DIVU    = 6'b01_1011;

endpackage

// File: rtl/div.sv
// div: iterative restoring divider for DIV / DIVU, one quotient bit per clock.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   signed_div_i 1 = DIV (signed), 0 = DIVU
//   opdata1_i    dividend (rs), sampled only when an operation is accepted
//   opdata2_i    divisor  (rt), sampled only when an operation is accepted
//   start_i      request, held by EX until ready_o is seen
//   annul_i      abort an operation in progress
//   result_o     {remainder, quotient}, valid while ready_o = 1
//   ready_o      result valid
//
// Build option
//   DIV_EARLY_OUT_EN : when defined, a dividend whose magnitude is below the
//   divisor magnitude finishes through the short divide-by-zero path
//   (quotient 0, remainder = dividend). Results are identical either way.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [4:0] LAST_CNT = 5'(DATA_W - 1);

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic              n);
    return n ? -v : v;
  endfunction

  div_state_e          state, state_nx;
  logic [4:0]          cnt, cnt_nx;
  logic                ready_nx;
  logic [2*DATA_W-1:0] result_nx;

  // The partial remainder is always below the divisor after a step, so its
  // 33rd bit is zero between iterations and only the low DATA_W bits are kept.
  logic [DATA_W-1:0]   rem, rem_nx;
  logic [DATA_W-1:0]   quo, quo_nx;
  logic [DATA_W-1:0]   dsr, dsr_nx;
  logic                neg_q, neg_q_nx;
  logic                neg_r, neg_r_nx;

  logic                sgn1, sgn2;
  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W:0]     shifted_r;
  logic [DATA_W:0]     trial;

  assign sgn1 = signed_div_i & opdata1_i[DATA_W-1];
  assign sgn2 = signed_div_i & opdata2_i[DATA_W-1];
  assign mag1 = neg_if(opdata1_i, sgn1);
  assign mag2 = neg_if(opdata2_i, sgn2);

  assign shifted_r = {rem, quo[DATA_W-1]};
  assign trial     = shifted_r - {1'b0, dsr};

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ready_nx  = ready_o;
    result_nx = result_o;
    rem_nx    = rem;
    quo_nx    = quo;
    dsr_nx    = dsr;
    neg_q_nx  = neg_q;
    neg_r_nx  = neg_r;

    case (state)
      DIV_FREE: begin
        ready_nx  = DIV_RESULT_NOT_READY;
        result_nx = '0;
        if (start_i == DIV_START && !annul_i) begin
          dsr_nx   = mag2;
          neg_q_nx = sgn1 ^ sgn2;
          neg_r_nx = sgn1;
          if (opdata2_i == '0) begin
            state_nx = DIV_BY_ZERO;
            rem_nx   = '0;
            quo_nx   = '0;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (mag1 < mag2) begin
            // Remainder magnitude is the dividend itself; the sign fix-up
            // in DIV_END restores the original signed dividend.
            state_nx = DIV_BY_ZERO;
            rem_nx   = mag1;
            quo_nx   = '0;
          end
`endif
          else begin
            state_nx = DIV_ON;
            cnt_nx   = '0;
            rem_nx   = '0;
            quo_nx   = mag1;
          end
        end
      end

      DIV_BY_ZERO: begin
        state_nx = DIV_END;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_nx  = DIV_FREE;
          ready_nx  = DIV_RESULT_NOT_READY;
          result_nx = '0;
        end else begin
          // Quotient register doubles as the dividend shift source: each step
          // pulls its MSB into the remainder and appends the new quotient bit.
          quo_nx = {quo[DATA_W-2:0], ~trial[DATA_W]};
          rem_nx = trial[DATA_W] ? shifted_r[DATA_W-1:0] : trial[DATA_W-1:0];
          cnt_nx = cnt + 5'd1;
          if (cnt == LAST_CNT) state_nx = DIV_END;
        end
      end

      DIV_END: begin
        if (start_i == DIV_START) begin
          ready_nx  = DIV_RESULT_READY;
          result_nx = {neg_if(rem, neg_r), neg_if(quo, neg_q)};
        end else begin
          state_nx  = DIV_FREE;
          ready_nx  = DIV_RESULT_NOT_READY;
          result_nx = '0;
        end
      end

      default: state_nx = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
      result_o <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ready_o  <= ready_nx;
      result_o <= result_nx;
    end
  end

  always_ff @(posedge clk) begin
    rem   <= rem_nx;
    quo   <= quo_nx;
    dsr   <= dsr_nx;
    neg_q <= neg_q_nx;
    neg_r <= neg_r_nx;
  end

endmodule

// File: tb/tb_div.sv
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (b == 0) return 3;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 3;
`endif
    return (ma == mb + 1) ? 34 : 34;
  endfunction

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    int   edges;
    logic seen;
    logic [63:0] exp;
    exp = ref_div(s, a, b);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        // operands must be ignored once latched
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = $urandom_range(0, 1);
      end
      if (ready_o) seen = 1'b1;
    end
    check($sformatf("lat %0d %h/%h", s, a, b), 64'(edges), 64'(ref_lat(s, a, b)));
    check($sformatf("res %0d %h/%h", s, a, b), result_o, exp);
    @(negedge clk);
    start_i = 1'b0;
    check("hold_ready", {63'd0, ready_o}, 64'd1);
    @(posedge clk);
    #1;
    check("drop_ready", {63'd0, ready_o}, 64'd0);
    check("drop_result", result_o, 64'd0);
  endtask

  initial begin
    logic seen;
    logic [31:0] a, b;
    logic s;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready", {63'd0, ready_o}, 64'd0);

    // directed cases
    do_div(1'b0, 32'd100, 32'd7);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    do_div(1'b1, 32'd5, 32'd0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(1'b0, 32'd3, 32'd9);
    do_div(1'b1, 32'hFFFF_FFFD, 32'd9);

    // start with annul in DivFree: no operation accepted
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd0; signed_div_i = 1'b0;
    start_i = 1'b1; annul_i = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    check("start_annul", {63'd0, seen}, 64'd0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;

    // annul at cnt=10
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0;
    start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    check("annul_noready", {63'd0, seen}, 64'd0);
    do_div(1'b0, 32'd9, 32'd3);

    // async reset mid-DivOn
    @(negedge clk);
    opdata1_i = 32'd12345; opdata2_i = 32'd17; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_on_ready", {63'd0, ready_o}, 64'd0);
    check("arst_on_result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;

    // async reset while a result is being presented
    @(negedge clk);
    opdata1_i = 32'd77; opdata2_i = 32'd0; start_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre_arst_ready", {63'd0, ready_o}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_end_ready", {63'd0, ready_o}, 64'd0);
    check("arst_end_result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;
    do_div(1'b1, 32'hFFFF_FF00, 32'd16);

    // randomized
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 300);
        4:       b = -($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      do_div(s, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
